// File: rtl/exclusive_min_n_pkg.sv
// Shared types and helpers for the race-logic winner-take-all blocks.
package race_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    WIN  = 2'd1,
    TIE  = 2'd2,
    DONE = 2'd3
  } xmin_state_t;

  typedef enum logic {
    MODE_PULSE = 1'b0,
    MODE_LEVEL = 1'b1
  } out_mode_t;

  localparam int DEFAULT_GAMMA_CYCLE_WIDTH = 16;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/exclusive_min_n_rise_detect.sv
// Per-channel rising-edge detector; the history register is loaded during grst so a
// level already high at the start of a gamma cycle never counts as an event.
module rise_detect #(
  parameter int N = 4
) (
  input  logic         aclk,
  input  logic         grst,
  input  logic [N-1:0] in,
  output logic [N-1:0] rise
);

  logic [N-1:0] in_q_r;

  // input history, refreshed every cycle including reset
  always_ff @(posedge aclk) begin
    if (grst) begin
      in_q_r <= in;
    end else begin
      in_q_r <= in;
    end
  end

  assign rise = in & ~in_q_r;

endmodule

// File: rtl/exclusive_min_n.sv
// N-input exclusive-min: first single rising edge in a gamma cycle wins and drives q;
// a tie for first place or an empty window leaves q low until the next grst.
module exclusive_min_n
  import race_pkg::*;
#(
  parameter int        N                 = 4,
  parameter int        GAMMA_CYCLE_WIDTH = DEFAULT_GAMMA_CYCLE_WIDTH,
  parameter int        PULSE_WIDTH       = 8,
  parameter out_mode_t MODE              = MODE_PULSE
) (
  input  logic                                 aclk,
  input  logic                                 grst,
  input  logic [N-1:0]                         in,
  output logic [N-1:0]                         q,
  output logic                                 win_valid,
  output logic [$clog2(N)-1:0]                 win_idx,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] win_time,
  output logic                                 tie
);

  localparam int IW  = $clog2(N);
  localparam int TW  = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int TCW = $clog2(GAMMA_CYCLE_WIDTH + 1);
  localparam int PCW = $clog2(PULSE_WIDTH + 1);
  localparam logic [TCW-1:0] T_END  = TCW'(GAMMA_CYCLE_WIDTH);
  localparam logic [PCW-1:0] P_LOAD = PCW'(PULSE_WIDTH);

  if (!is_pow2(GAMMA_CYCLE_WIDTH)) begin : g_gamma_check
    $error("exclusive_min_n: GAMMA_CYCLE_WIDTH must be a power of 2");
  end
  if ((PULSE_WIDTH < 1) || (PULSE_WIDTH > GAMMA_CYCLE_WIDTH)) begin : g_pulse_check
    $error("exclusive_min_n: PULSE_WIDTH out of range");
  end

  logic [N-1:0]   rise_s;
  logic [TCW-1:0] t_r;
  logic [PCW-1:0] pcnt_r;
  xmin_state_t    state_r;
  xmin_state_t    state_s;
  logic           seen_s;
  logic           multi_s;
  logic [IW-1:0]  enc_s;
  logic           t_live_s;
  logic           decide_s;
  logic [N-1:0]   onehot_s;
  logic [N-1:0]   q_s;

  rise_detect #(.N(N)) u_rise (
    .aclk (aclk),
    .grst (grst),
    .in   (in),
    .rise (rise_s)
  );

  // any/multiple-rise flags and lowest-index priority encode
  always_comb begin
    seen_s  = 1'b0;
    multi_s = 1'b0;
    enc_s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      multi_s = multi_s | (seen_s & rise_s[i]);
      seen_s  = seen_s | rise_s[i];
      enc_s   = rise_s[i] ? IW'(i) : enc_s;
    end
  end

  assign t_live_s = (t_r < T_END);

  // next-state: decisions are only taken from WAIT inside the window
  always_comb begin
    state_s = state_r;
    case (state_r)
      WAIT: begin
        if (!t_live_s) begin
          state_s = DONE;
        end else if (multi_s) begin
          state_s = TIE;
        end else if (seen_s) begin
          state_s = WIN;
        end else begin
          state_s = WAIT;
        end
      end
      WIN, TIE, DONE: state_s = state_r;
      default:        state_s = WAIT;
    endcase
  end

  // next q: winner one-hot while the pulse counter runs, or always in level mode
  always_comb begin
    decide_s = (state_r == WAIT) && (state_s == WIN);
    onehot_s = {{(N-1){1'b0}}, 1'b1} << win_idx;
    if ((state_r == WIN) && ((MODE == MODE_LEVEL) || (pcnt_r != '0))) begin
      q_s = onehot_s;
    end else begin
      q_s = '0;
    end
  end

  // state, time counter, pulse counter and registered outputs
  always_ff @(posedge aclk) begin
    if (grst) begin
      state_r   <= WAIT;
      t_r       <= '0;
      pcnt_r    <= '0;
      q         <= '0;
      win_valid <= 1'b0;
      win_idx   <= '0;
      win_time  <= '0;
      tie       <= 1'b0;
    end else begin
      state_r   <= state_s;
      t_r       <= t_live_s ? (t_r + TCW'(1)) : t_r;
      q         <= q_s;
      win_valid <= (state_r == WIN);
      tie       <= (state_r == TIE);
      if (decide_s) begin
        win_idx  <= enc_s;
        win_time <= t_r[TW-1:0];
        pcnt_r   <= P_LOAD;
      end else if ((state_r == WIN) && (pcnt_r != '0)) begin
        pcnt_r <= pcnt_r - PCW'(1);
      end else begin
        pcnt_r <= pcnt_r;
      end
    end
  end

endmodule

// File: tb/tb_exclusive_min_n.sv
// Scoreboard bench: pulse-mode and level-mode instances share the same stimulus.
module tb_exclusive_min_n;
  import race_pkg::*;

  localparam int NEVER = 1000;

  typedef struct packed {
    logic [3:0] qp;
    logic [3:0] ql;
    logic       v;
    logic       chk_it;
    logic [1:0] idx;
    logic [3:0] tm;
    logic       tie;
  } exp_t;

  logic       aclk;
  logic       grst;
  logic [3:0] in_s;
  logic [3:0] qp, ql;
  logic       vp, vl, tp, tl;
  logic [1:0] ip, il;
  logic [3:0] mp, ml;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   cyc;

  exclusive_min_n #(.N(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .MODE(MODE_PULSE)) u_pulse (
    .aclk(aclk), .grst(grst), .in(in_s), .q(qp), .win_valid(vp),
    .win_idx(ip), .win_time(mp), .tie(tp)
  );

  exclusive_min_n #(.N(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .MODE(MODE_LEVEL)) u_level (
    .aclk(aclk), .grst(grst), .in(in_s), .q(ql), .win_valid(vl),
    .win_idx(il), .win_time(ml), .tie(tl)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic cmp(input string nm, input int c, input logic [3:0] qa, input logic va,
                     input logic [1:0] ia, input logic [3:0] ma, input logic ta,
                     input logic [3:0] qe, input exp_t e);
    logic bad;
    bad = (qa !== qe) || (va !== e.v) || (ta !== e.tie);
    if (e.chk_it) bad = bad || (ia !== e.idx) || (ma !== e.tm);
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s cyc=%0d actual q=%b v=%b idx=%0d time=%0d tie=%b required q=%b v=%b idx=%0d time=%0d tie=%b (idx/time checked=%b)",
               nm, c, qa, va, ia, ma, ta, qe, e.v, e.idx, e.tm, e.tie, e.chk_it);
    end
  endtask

  // monitor: pop one expected record per pushed cycle and compare both instances
  always @(negedge aclk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("pulse", cyc, qp, vp, ip, mp, tp, e.qp, e);
      cmp("level", cyc, ql, vl, il, ml, tl, e.ql, e);
      cyc++;
    end
  end

  // one gamma cycle: grst edge, then len cycles; rt[i] = t at which in[i] rises
  // kind: 0 = no winner, 1 = winner, 2 = tie
  task automatic run_gamma(input int r0, input int r1, input int r2, input int r3,
                           input logic [3:0] init_in, input int kind,
                           input int eidx, input int etime, input int len);
    int   rt[4];
    exp_t e;
    logic [3:0] oh;
    rt[0] = r0; rt[1] = r1; rt[2] = r2; rt[3] = r3;
    oh = 4'b0001 << eidx;
    grst = 1'b1;
    in_s = init_in;
    @(posedge aclk);
    e = '{qp: 4'b0, ql: 4'b0, v: 1'b0, chk_it: 1'b1, idx: 2'd0, tm: 4'd0, tie: 1'b0};
    sb.push_back(e);
    #1;
    grst = 1'b0;
    for (int k = 0; k < len; k++) begin
      for (int i = 0; i < 4; i++) in_s[i] = init_in[i] | (rt[i] <= k);
      @(posedge aclk);
      e.v   = (kind == 1) && (k >= etime + 1);
      e.tie = (kind == 2) && (k >= etime + 1);
      e.qp  = ((kind == 1) && (k >= etime + 1) && (k <= etime + 8)) ? oh : 4'b0;
      e.ql  = ((kind == 1) && (k >= etime + 1)) ? oh : 4'b0;
      if ((kind != 1) || (k < etime)) begin
        e.chk_it = 1'b1; e.idx = 2'd0; e.tm = 4'd0;
      end else if (k > etime) begin
        e.chk_it = 1'b1; e.idx = 2'(eidx); e.tm = 4'(etime);
      end else begin
        e.chk_it = 1'b0; e.idx = 2'd0; e.tm = 4'd0;
      end
      sb.push_back(e);
      #1;
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    grst = 1'b1; in_s = 4'b0;
    // 1: silent window, runs past t=16 into DONE
    run_gamma(NEVER, NEVER, NEVER, NEVER, 4'b0000, 0, 0, 0, 20);
    // 2: in[2] at t=3 wins, in[0] at t=5 ignored
    run_gamma(5, NEVER, 3, NEVER, 4'b0000, 1, 2, 3, 16);
    // 3: tie of in[1]/in[3] at t=2, late in[0] ignored
    run_gamma(6, 2, NEVER, 2, 4'b0000, 2, 0, 2, 18);
    // 4: last legal slot t=15; then a rise at t=16 is outside the window
    run_gamma(NEVER, NEVER, NEVER, 15, 4'b0000, 1, 3, 15, 20);
    run_gamma(NEVER, NEVER, NEVER, 16, 4'b0000, 0, 0, 0, 20);
    // 5: grst after four pulse cycles; in[1] held high across grst is no event
    run_gamma(NEVER, 3, 1, NEVER, 4'b0000, 1, 2, 1, 6);
    run_gamma(NEVER, NEVER, NEVER, NEVER, 4'b0010, 0, 0, 0, 18);
    // 6: back-to-back winners 0 then 3
    run_gamma(0, NEVER, NEVER, NEVER, 4'b0000, 1, 0, 0, 12);
    run_gamma(NEVER, 9, NEVER, 7, 4'b0000, 1, 3, 7, 18);
    // pulse runs past the end of the window without being clipped
    run_gamma(NEVER, 12, 13, NEVER, 4'b0000, 1, 1, 12, 24);
    grst = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual pending=%0d required pending=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
